axi_wr_engine: RTL



---
 rtl/axi_wr_pkg.sv | 43 ++++
 rtl/axi_wr_engine_if.sv | 47 ++++
 rtl/axi_sync_fifo.sv | 46 ++++
 rtl/axi_wr_engine.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/axi_wr_pkg.sv
// Shared encodings, AW queue entry layout and burst address generation
// for the AXI4 write-path engine.
package axi_wr_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] W_IDLE  = 1'b0;
    localparam logic [0:0] W_BURST = 1'b1;

    // Everything about a queued burst except its start address.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       err;
    } aw_ctrl_t;

    // Address of the beat following addr; evaluated at 64 bits, callers truncate.
    function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                              input logic [7:0]  len,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [63:0] bytes;
        logic [63:0] aligned;
        logic [63:0] wsize;
        logic [63:0] nxt;
        bytes   = 64'd1 << size;
        aligned = addr & ~(bytes - 64'd1);
        wsize   = bytes * (64'(len) + 64'd1);
        nxt     = aligned + bytes;
        case (burst)
            BURST_INCR: next_addr = nxt;
            BURST_WRAP: next_addr = (addr & ~(wsize - 64'd1)) | (nxt & (wsize - 64'd1));
            default:    next_addr = addr;
        endcase
    endfunction

endpackage

// File: rtl/axi_wr_engine_if.sv
// AXI4 write channels plus the registered memory-side write port.
interface axi_wr_engine_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic [AW-1:0]   s_awaddr;
    logic [7:0]      s_awlen;
    logic [2:0]      s_awsize;
    logic [1:0]      s_awburst;
    logic            s_awvalid;
    logic            s_awready;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_wlast;
    logic            s_wvalid;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic [DW/8-1:0] mem_strb;
    logic            mem_valid;
    logic            mem_ready;

    modport slave (
        input  s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_wready,
        output s_bresp, s_bvalid,
        input  s_bready,
        output mem_addr, mem_data, mem_strb, mem_valid,
        input  mem_ready
    );

    modport master (
        output s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_wready,
        input  s_bresp, s_bvalid,
        output s_bready,
        input  mem_addr, mem_data, mem_strb, mem_valid,
        output mem_ready
    );
endinterface

// File: rtl/axi_sync_fifo.sv
// Single-clock FIFO with registered storage and a show-ahead head word;
// push when full and pop when empty are ignored.
module axi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer bit distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (PW+1)'(1);
            if (do_pop)  rptr <= rptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[PW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

endmodule

// File: rtl/axi_wr_engine.sv
// AXI4 write slave: queues AW requests, walks bursts beat by beat into a
// registered memory write port and returns in-order B responses.
module axi_wr_engine
    import axi_wr_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 64,
    parameter int OUTSTANDING = 4
) (
    input  logic           axi_aclk,
    input  logic           axi_aresetn,
    axi_wr_engine_if.slave bus
);
    localparam int OCW       = $clog2(OUTSTANDING) + 1;
    localparam int QW        = AW + $bits(aw_ctrl_t);
    localparam int BYTES_MAX = DW / 8;

    function automatic logic aw_err(input logic [7:0] len,
                                    input logic [2:0] size,
                                    input logic [1:0] burst);
        logic bad_wrap;
        logic too_wide;
        bad_wrap = (burst == BURST_WRAP) &&
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        too_wide = (32'd1 << size) > 32'(BYTES_MAX);
        return (burst == 2'b11) || too_wide || bad_wrap;
    endfunction

    logic [OCW-1:0]  oc;
    logic            aw_hs;
    logic            w_hs;
    logic            b_hs;
    logic            aw_full;
    logic            aw_empty;
    logic            aw_pop;
    logic [QW-1:0]   aw_head;
    logic [AW-1:0]   head_addr;
    aw_ctrl_t        head_ctrl;
    aw_ctrl_t        push_ctrl;
    logic            b_full;
    logic            b_empty;
    logic            b_push;
    logic [1:0]      b_resp;
    logic [0:0]      state;
    logic [AW-1:0]   cur_addr;
    aw_ctrl_t        cur_ctrl;
    logic [7:0]      beat;
    logic            lerr;
    logic            is_last;
    logic            wlast_mis;
    logic            load;
    logic            wready;
    logic            vld_p1;
    logic [AW-1:0]   addr_p1;
    logic [DW-1:0]   data_p1;
    logic [DW/8-1:0] strb_p1;

    assign bus.s_awready = (oc < OCW'(OUTSTANDING)) && !aw_full;
    assign aw_hs         = bus.s_awvalid && bus.s_awready;
    assign b_hs          = !b_empty && bus.s_bready;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            oc <= '0;
        end else if (aw_hs && !b_hs) begin
            oc <= oc + OCW'(1);
        end else if (!aw_hs && b_hs) begin
            oc <= oc - OCW'(1);
        end
    end

    assign push_ctrl = '{len:   bus.s_awlen,
                         size:  bus.s_awsize,
                         burst: bus.s_awburst,
                         err:   aw_err(bus.s_awlen, bus.s_awsize, bus.s_awburst)};

    axi_sync_fifo #(.WIDTH(QW), .DEPTH(OUTSTANDING)) u_aw_q (
        .clk   (axi_aclk),
        .rst_n (axi_aresetn),
        .push  (aw_hs),
        .wdata ({bus.s_awaddr, push_ctrl}),
        .pop   (aw_pop),
        .rdata (aw_head),
        .full  (aw_full),
        .empty (aw_empty)
    );

    assign {head_addr, head_ctrl} = aw_head;

    // Stage p0: beat walker, one W beat per handshake.
    assign wready    = (state == W_BURST) && (!vld_p1 || bus.mem_ready);
    assign w_hs      = bus.s_wvalid && wready;
    assign is_last   = (beat == cur_ctrl.len);
    assign wlast_mis = bus.s_wlast != is_last;
    // Reloading straight from the last beat avoids an IDLE bubble between bursts.
    assign load      = !aw_empty && ((state == W_IDLE) || (w_hs && is_last));
    assign aw_pop    = load;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state <= W_IDLE;
            beat  <= '0;
            lerr  <= 1'b0;
        end else if (load) begin
            state <= W_BURST;
            beat  <= '0;
            lerr  <= 1'b0;
        end else if (w_hs) begin
            beat <= beat + 8'd1;
            lerr <= lerr | wlast_mis;
            if (is_last) state <= W_IDLE;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (load) begin
            cur_addr <= head_addr;
            cur_ctrl <= head_ctrl;
        end else if (w_hs) begin
            cur_addr <= AW'(next_addr(64'(cur_addr), cur_ctrl.len,
                                      cur_ctrl.size, cur_ctrl.burst));
        end
    end

    // Stage p1: registered memory beat, held until mem_ready.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            strb_p1 <= '0;
        end else if (w_hs && !cur_ctrl.err) begin
            vld_p1  <= 1'b1;
            addr_p1 <= cur_addr;
            data_p1 <= bus.s_wdata;
            strb_p1 <= bus.s_wstrb;
        end else if (bus.mem_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.s_wready  = wready;
    assign bus.mem_valid = vld_p1;
    assign bus.mem_addr  = addr_p1;
    assign bus.mem_data  = data_p1;
    assign bus.mem_strb  = strb_p1;

    // B queue depth matches oc, so the full guard never fires in practice.
    assign b_push = w_hs && is_last && !b_full;
    assign b_resp = (cur_ctrl.err || lerr || wlast_mis) ? RESP_SLVERR : RESP_OKAY;

    axi_sync_fifo #(.WIDTH(2), .DEPTH(OUTSTANDING)) u_b_q (
        .clk   (axi_aclk),
        .rst_n (axi_aresetn),
        .push  (b_push),
        .wdata (b_resp),
        .pop   (b_hs),
        .rdata (bus.s_bresp),
        .full  (b_full),
        .empty (b_empty)
    );

    assign bus.s_bvalid = !b_empty;

endmodule
